// File: rtl/instr_encoder_pkg.sv
// Shared types for the instruction encoder: opcode and funct3 encodings,
// instruction format classes, rejection codes and small helper functions.
package instr_encoder_pkg;

  typedef enum logic [6:0] {
    OP_LOAD                 = 7'h03,
    OP_LOAD_FP              = 7'h07,
    OP_MISC_MEMORY          = 7'h0F,
    OP_ARITHMETIC_IMMEDIATE = 7'h13,
    OP_AUIPC                = 7'h17,
    OP_STORE                = 7'h23,
    OP_STORE_FP             = 7'h27,
    OP_ATOMIC_MEMORY        = 7'h2F,
    OP_ARITHMETIC           = 7'h33,
    OP_LUI                  = 7'h37,
    OP_BRANCH               = 7'h63,
    OP_JALR                 = 7'h67,
    OP_JAL                  = 7'h6F,
    OP_SYSTEM               = 7'h73
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_SUB      = 3'd0,
    F3_SLLI         = 3'd1,
    F3_SLT          = 3'd2,
    F3_SLTU         = 3'd3,
    F3_XOR          = 3'd4,
    F3_SRLI_OR_SRAI = 3'd5,
    F3_OR           = 3'd6,
    F3_AND          = 3'd7
  } funct3_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
  } format_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OPCODE   = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_ALIGN    = 2'd3
  } err_code_e;

  // Map an opcode to its packing format; anything this encoder cannot emit
  // (FP, atomics, unknown values) falls into FMT_NONE.
  function automatic format_e format_of(logic [6:0] op);
    format_e f;
    case (op)
      OP_ARITHMETIC:                       f = FMT_R;
      OP_ARITHMETIC_IMMEDIATE, OP_LOAD,
      OP_JALR, OP_SYSTEM, OP_MISC_MEMORY:  f = FMT_I;
      OP_STORE:                            f = FMT_S;
      OP_BRANCH:                           f = FMT_B;
      OP_LUI, OP_AUIPC:                    f = FMT_U;
      OP_JAL:                              f = FMT_J;
      default:                             f = FMT_NONE;
    endcase
    return f;
  endfunction

  // True when v, read as two's complement, fits in a w-bit signed field:
  // every bit from w-1 upward must equal the sign.
  function automatic logic fits_signed(logic [31:0] v, int unsigned w);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << (w - 1);
    return ((v & hi_mask) == 32'h0) || ((v & hi_mask) == hi_mask);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: scrambles the immediate into the format chosen by
// the opcode and flags unsupported opcodes, range and alignment violations.
// A rejected request always yields an all-zero word.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic [1:0]  err_code
);

  format_e   fmt;
  logic      is_shift;
  err_code_e code;
  logic [31:0] word;

  assign fmt      = format_of(opcode);
  assign is_shift = (opcode == OP_ARITHMETIC_IMMEDIATE) &&
                    ((funct3 == F3_SLLI) || (funct3 == F3_SRLI_OR_SRAI));

  // Pack fields and classify the request; alignment outranks range.
  always_comb begin
    code = ERR_NONE;
    word = '0;
    case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        if (is_shift) begin
          if (imm[31:5] != '0) code = ERR_RANGE;
          word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        end else begin
          if (!fits_signed(imm, 12)) code = ERR_RANGE;
          word = {imm[11:0], rs1, funct3, rd, opcode};
        end
      end
      FMT_S: begin
        if (!fits_signed(imm, 12)) code = ERR_RANGE;
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      end
      FMT_B: begin
        if (imm[0])                      code = ERR_ALIGN;
        else if (!fits_signed(imm, 13))  code = ERR_RANGE;
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      end
      FMT_U: begin
        if (imm[11:0] != '0) code = ERR_RANGE;
        word = {imm[31:12], rd, opcode};
      end
      FMT_J: begin
        if (imm[0])                      code = ERR_ALIGN;
        else if (!fits_signed(imm, 21))  code = ERR_RANGE;
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      end
      default: code = ERR_OPCODE;
    endcase
  end

  assign instr    = (code == ERR_NONE) ? word : 32'h0;
  assign err_code = code;

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction encoder: one request in, one packed word out a cycle
// later, each good word tagged with its byte address in a MEM_DEPTH-word
// program image. Rejected requests produce an error word that uses no address.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and payload until that edge; the output word
// stays stable while out_valid && !out_ready.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [1:0]  out_err_code,
  output logic        full,
  output logic [7:0]  err_count
);

  localparam int IDX_W = $clog2(MEM_DEPTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             out_err_q, out_err_d;
  logic [1:0]       out_code_q, out_code_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic [31:0] pack_instr;
  logic [1:0]  pack_code;
  logic        out_accept;
  logic        last_slot_busy;

  instr_pack u_pack (
    .opcode   (in_opcode),
    .funct3   (in_funct3),
    .funct7   (in_funct7),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .imm      (in_imm),
    .instr    (pack_instr),
    .err_code (pack_code)
  );

  assign out_accept = out_valid_q && out_ready;

  // The last address is already claimed by the word in the output register;
  // taking another request now would produce a word with no address left.
  assign last_slot_busy = out_valid_q && !out_err_q &&
                          (idx_q == IDX_W'(MEM_DEPTH - 1));

  assign in_ready = (state_q == ST_RUN) && !start && !last_slot_busy &&
                    (!out_valid_q || out_ready);

  // Next-state: start restarts the image, otherwise retire and capture words.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    out_code_d  = out_code_q;
    idx_d       = idx_q;
    err_cnt_d   = err_cnt_q;
    if (start) begin
      state_d     = ST_RUN;
      out_valid_d = 1'b0;
      out_instr_d = 32'h0;
      out_err_d   = 1'b0;
      out_code_d  = 2'd0;
      idx_d       = '0;
      err_cnt_d   = 8'd0;
    end else begin
      if (out_accept) begin
        out_valid_d = 1'b0;
        if (out_err_q) begin
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(MEM_DEPTH - 1)) state_d = ST_FULL;
        end
      end
      if (in_valid && in_ready) begin
        out_valid_d = 1'b1;
        out_instr_d = pack_instr;
        out_err_d   = (pack_code != 2'd0);
        out_code_d  = pack_code;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_err_q   <= 1'b0;
      out_code_q  <= 2'd0;
      idx_q       <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      out_code_q  <= out_code_d;
      idx_q       <= idx_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_err      = out_err_q;
  assign out_err_code = out_code_q;
  assign out_addr     = {{(30 - IDX_W){1'b0}}, idx_q, 2'b00};
  assign full         = (state_q == ST_FULL);
  assign err_count    = err_cnt_q;

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter MEM_DEPTH, default 256, is the number of 32-bit words in the target instruction memory; it SHALL be a power of two, 2..65536.
REQ-002 Ports SHALL be as follows (clock and reset first):
  clk  input  1  single clock; all logic on rising edge
  reset  input  1  synchronous, active-high reset
  start  input  1  single-cycle pulse that begins a new program image at word address 0
  in_valid  input  1  encode request present
  in_ready  output  1  request accepted this cycle when in_valid && in_ready
  in_opcode  input  7  OpCode value
  in_funct3  input  3  funct3 field
  in_funct7  input  7  funct7 field (R-type, shift-immediate)
  in_rd / in_rs1 / in_rs2  input  5 each  register indices
  in_imm  input  32  signed immediate or byte offset, unscrambled
  out_valid  output  1  encoded word present
  out_ready  input  1  downstream accepts word when out_valid && out_ready
  out_instr  output  32  encoded instruction word
  out_addr  output  32  byte address of out_instr (word index * 4)
  out_err  output  1  request rejected; out_instr is 0 and no address is consumed
  out_err_code  output  2  0 none, 1 unsupported opcode, 2 immediate out of range, 3 misaligned offset
  full  output  1  MEM_DEPTH words emitted since start
  err_count  output  8  saturating count of rejected requests since start

Function
REQ-003 The FSM SHALL have states IDLE, RUN and FULL; reset -> IDLE; start -> RUN from any state; RUN -> FULL when the MEM_DEPTH-th non-error word is accepted at the output.
REQ-004 in_ready SHALL be 1 only in RUN, with start low, and with (!out_valid || out_ready).
REQ-005 Latency SHALL be one cycle: an accepted request appears on out_* the next cycle, held stable until out_ready, which gives full throughput when out_ready is held high.
REQ-006 R-type (ARITHMETIC) SHALL pack funct7|rs2|rs1|funct3|rd|opcode.
REQ-007 I-type (ARITHMETIC_IMMEDIATE, LOAD, JALR, SYSTEM, MISC_MEMORY) SHALL pack imm[11:0]|rs1|funct3|rd|opcode, with imm in -2048..2047; for funct3 SLLI or SRLI_OR_SRAI the bits [31:25] SHALL be funct7 and imm SHALL be 0..31.
REQ-008 S-type (STORE) SHALL pack imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode, with imm in -2048..2047.
REQ-009 B-type (BRANCH) SHALL pack imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode, with imm in -4096..4094.
REQ-010 U-type (LUI, AUIPC) SHALL pack imm[31:12]|rd|opcode, and imm[11:0] SHALL be 0.
REQ-011 J-type (JAL) SHALL pack imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode, with imm in -1048576..1048574.
REQ-012 For B-type and J-type, imm[0]=1 SHALL give code 3; code 3 SHALL take priority over code 2.
REQ-013 LOAD_FP, STORE_FP, ATOMIC_MEMORY and non-enumerated opcodes SHALL give code 1.
REQ-014 Any other range violation SHALL give code 2.
REQ-015 An errored word SHALL set out_err=1 and out_instr=0, with out_addr equal to the next unused address, and SHALL increment err_count (saturating at 255) when accepted at the output.
REQ-016 The word index SHALL increment by 1 on each accepted non-error output word, and SHALL never wrap; full=1 in FULL.
REQ-017 start SHALL clear out_valid, word index, err_count and full in the same edge, discarding any pending word; a request presented with start is not accepted.
REQ-018 Fields unused by a format (e.g. funct7 for I-type non-shift) SHALL be ignored.

Reset
REQ-019 On reset the block SHALL enter IDLE with in_ready=0, out_valid=0, out_instr=0, out_addr=0, out_err=0, out_err_code=0, full=0 and err_count=0, discarding any pending word.

Structure
REQ-020 The format types, the OpCode and funct3 enums, and a new error-code enum SHALL live in the shared common package.
REQ-021 Packing and range checks SHALL be one combinational sub-module, instr_pack, instantiated once ahead of the output register.

Verification
REQ-022 ADD x3,x1,x2 (funct3 0, funct7 0) -> out_instr 0x002081B3, out_addr 0.
REQ-023 SW x5,-4(x2) -> 0xFE512E23; BEQ x1,x2,+8 -> 0x00208463; BEQ with imm 7 -> out_err=1, code 3, address unchanged.
REQ-024 JAL x1,+2048 -> 0x001000EF; JAL with imm 0x100000 -> code 2; opcode 0x2F -> code 1; LUI with imm 0x12345001 -> code 2.
REQ-025 MEM_DEPTH=4: 6 back-to-back requests with out_ready low for cycles 2-4 -> out_instr stable while stalled, addresses 0,4,8,12, full=1, in_ready=0 after the 4th word; start -> next word at address 0.
REQ-026 reset asserted with out_valid=1 and out_ready=0 -> next cycle out_valid=0, state IDLE, in_ready=0 until start.
